// File: rtl/lc3b_types.sv
// Shared LC-3b types for the L1 memory hierarchy.
// Line/word widths, arbiter state encoding and line-align helper.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_L1_line;

  localparam int L1_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  function automatic lc3b_word line_align(lc3b_word a);
    lc3b_word mask;
    mask = '1 << L1_OFFSET_BITS;
    return a & mask;
  endfunction

endpackage

// File: rtl/line_req_reg.sv
// Latched downstream request: line address, write data and type.
// Loaded on grant, cleared on completion so idle outputs read zero.
module line_req_reg
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [15:0]  addr_i,
  input  logic [127:0] wdata_i,
  input  logic         write_i,
  output logic [15:0]  addr_o,
  output logic [127:0] wdata_o,
  output logic         write_o
);

  lc3b_word    addr_q;
  lc3b_L1_line wdata_q;
  logic        write_q;

  // Capture the request fields whenever the arbiter loads or clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      write_q <= write_i;
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign write_o = write_q;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one line port between icache and dcache.
// One transaction at a time; request held stable from latches until resp.
module l1_mem_arbiter
  import lc3b_types::*;
#(
  parameter bit DCACHE_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  arb_state_t  state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        ld;
  lc3b_word    ld_addr;
  lc3b_L1_line ld_wdata;
  logic        ld_write;
  logic        wr_q;
  logic        d_req;
  logic        grant_d;

  line_req_reg u_req (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .addr_i  (ld_addr),
    .wdata_i (ld_wdata),
    .write_i (ld_write),
    .addr_o  (pmem_address),
    .wdata_o (pmem_wdata),
    .write_o (wr_q)
  );

  // State and round-robin history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= !DCACHE_FIRST;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  assign d_req   = d_read | d_write;
  assign grant_d = (i_read && d_req) ? !last_d_q : d_req;

  // Grant selection, downstream strobes and L1 responses
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    ld         = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    ld_write   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          ld       = 1'b1;
          ld_addr  = line_align(d_address);
          ld_write = d_write;
          ld_wdata = d_write ? d_wdata : '0;
        end else if (i_read) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          ld       = 1'b1;
          ld_addr  = line_align(i_address);
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
          ld      = 1'b1;
        end
      end
      SERVE_D: begin
        pmem_read  = !wr_q;
        pmem_write = wr_q;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
          ld      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized bench for l1_mem_arbiter against a transaction-level model.
// Agents model two L1 caches and a variable-latency memory.
module tb_l1_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  l1_mem_arbiter #(.DCACHE_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the port, what was granted, history
  int           m_owner;
  logic [15:0]  m_addr;
  logic         m_wr;
  logic [127:0] m_wdata;
  bit           m_last_d;
  int           m_lat;
  int           n_grant_i, n_grant_d;

  // Requester agents
  bit           i_pend, d_pend, i_gap, d_gap;
  logic [15:0]  i_a, d_a;
  logic [127:0] d_w;
  int           d_kind;

  task automatic model_reset();
    m_owner  = 0;
    m_addr   = '0;
    m_wr     = 1'b0;
    m_wdata  = '0;
    m_last_d = 1'b0;
    m_lat    = 0;
    i_pend   = 0;
    d_pend   = 0;
    i_gap    = 0;
    d_gap    = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".pr"}, pmem_read, 1'b0);
    check({tag, ".pw"}, pmem_write, 1'b0);
    check({tag, ".ir"}, i_resp, 1'b0);
    check({tag, ".dr"}, d_resp, 1'b0);
    check({tag, ".pa"}, pmem_address, 16'h0);
    check({tag, ".wd"}, pmem_wdata, 128'h0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive();
    if (i_gap) i_gap = 0;
    else if (!i_pend && $urandom_range(0, 2) == 0) begin
      i_pend = 1;
      i_a = 16'($urandom);
    end
    if (d_gap) d_gap = 0;
    else if (!d_pend && $urandom_range(0, 2) == 0) begin
      d_pend = 1;
      d_a = 16'($urandom);
      d_w = rnd128();
      d_kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
    end
    // Granted or idle requesters may wiggle; pending ones hold
    i_address = (i_pend && m_owner != 1) ? i_a : 16'($urandom);
    i_read = i_pend ? 1'b1
           : (m_owner != 0 ? 1'($urandom) : 1'b0);
    d_address = (d_pend && m_owner != 2) ? d_a : 16'($urandom);
    d_wdata = (d_pend && m_owner != 2) ? d_w : rnd128();
    if (d_pend) begin
      d_read  = (d_kind != 1);
      d_write = (d_kind != 0);
    end else if (m_owner != 0) begin
      d_read  = 1'($urandom);
      d_write = 1'($urandom);
    end else begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
    pmem_rdata = rnd128();
    pmem_resp = (m_owner != 0) ? (m_lat == 0)
              : ($urandom_range(0, 7) == 0);
  endtask

  task automatic check_cycle();
    bit done;
    done = (m_owner != 0) && pmem_resp;
    check("pmem_read", pmem_read,
          (m_owner == 1) || (m_owner == 2 && !m_wr));
    check("pmem_write", pmem_write, m_owner == 2 && m_wr);
    check("pmem_address", pmem_address,
          (m_owner != 0) ? m_addr : 16'h0);
    check("pmem_wdata", pmem_wdata,
          (m_owner == 2 && m_wr) ? m_wdata : 128'h0);
    check("i_resp", i_resp, done && m_owner == 1);
    check("d_resp", d_resp, done && m_owner == 2);
    if (done && m_owner == 1) check("i_rdata", i_rdata, pmem_rdata);
    if (done && m_owner == 2) check("d_rdata", d_rdata, pmem_rdata);
  endtask

  task automatic advance();
    bool_step();
  endtask

  task automatic bool_step();
    bit want_i, want_d, pick_d;
    if (m_owner != 0) begin
      if (pmem_resp) begin
        if (m_owner == 1) begin i_pend = 0; i_gap = 1; end
        else begin d_pend = 0; d_gap = 1; end
        m_owner = 0;
      end else begin
        m_lat--;
      end
    end else begin
      want_i = i_read;
      want_d = d_read || d_write;
      pick_d = (want_i && want_d) ? !m_last_d : want_d;
      if (want_i || want_d) begin
        m_lat = $urandom_range(0, 3);
        m_last_d = pick_d;
        if (pick_d) begin
          m_owner = 2;
          m_addr = d_address & 16'hFFF0;
          m_wr = d_write;
          m_wdata = d_wdata;
          n_grant_d++;
        end else begin
          m_owner = 1;
          m_addr = i_address & 16'hFFF0;
          m_wr = 1'b0;
          n_grant_i++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_read = 0; i_address = 0;
    d_read = 0; d_write = 0; d_address = 0; d_wdata = 0;
    pmem_rdata = 0; pmem_resp = 0;
    n_grant_i = 0; n_grant_d = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      @(negedge clk);
      if (cyc == 800 || cyc == 1600) begin
        // Reset in the middle of whatever is in flight
        rst = 1'b1;
        #1 check_idle_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        // Late response plus contention right after release
        i_pend = 1; i_a = 16'($urandom);
        d_pend = 1; d_a = 16'($urandom); d_w = rnd128(); d_kind = 0;
        drive();
        pmem_resp = 1'b1;
        #1;
        check_cycle();
        bool_step();
        check("post_reset_winner", 32'(m_owner), 32'd2);
        continue;
      end
      drive();
      #1;
      check_cycle();
      advance();
    end
    check("grants_i_seen", n_grant_i > 50, 1'b1);
    check("grants_d_seen", n_grant_d > 50, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Shares one line-granular downstream memory port (physical memory now, L2 later) between the instruction cache and data cache miss/writeback ports. It sits inside `cache_hierarchy`, between the two L1 caches and `pmem_*`. It grants one L1 transaction at a time, holds the downstream request stable until `pmem_resp`, and returns the response to the granted cache only. Arbitration is round-robin.

## Interface

- `DCACHE_FIRST`, default 1: which cache wins the first contention after reset. 1 = dcache, 0 = icache.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  icache line-fill request.
- `i_address`  in  16 (`lc3b_word`)  icache line address.
- `i_rdata`  out  128 (`lc3b_L1_line`)  fill data to icache.
- `i_resp`  out  1  icache transaction complete.
- `d_read`  in  1  dcache line-fill request.
- `d_write`  in  1  dcache writeback request.
- `d_address`  in  16  dcache line address.
- `d_wdata`  in  128  dcache writeback line.
- `d_rdata`  out  128  fill data to dcache.
- `d_resp`  out  1  dcache transaction complete.
- `pmem_read`, `pmem_write`  out  1 each  downstream strobes.
- `pmem_address`  out  16  downstream line address.
- `pmem_wdata`  out  128  downstream write line.
- `pmem_rdata`  in  128  downstream read line.
- `pmem_resp`  in  1  downstream done.

## Operation

- The FSM has three states: `IDLE`, `SERVE_I`, `SERVE_D`.
- In `IDLE`, requests are sampled:
  - Only icache requesting → `SERVE_I`.
  - Only dcache requesting → `SERVE_D`.
  - Both requesting → the cache that was not granted last wins. A 1-bit `last_d` register tracks this; it resets to `!DCACHE_FIRST`.
- On the grant edge, the arbiter latches the winner's address with bits [3:0] forced to 0. For a dcache write it also latches `d_wdata` and the write/read type. `last_d` updates on the same edge.
- `SERVE_x` drives `pmem_read`/`pmem_write` and `pmem_address`/`pmem_wdata` from the latches only. They stay stable regardless of L1 input changes.
- On `pmem_resp` in `SERVE_x`:
  - `x_resp` = 1 combinationally in the same cycle.
  - `x_rdata` = `pmem_rdata` in that cycle.
  - The next state is `IDLE`.
- `d_read` and `d_write` both high is illegal. If it occurs, the write is serviced and the read is ignored for that grant.
- `pmem_resp` in `IDLE` is ignored; no L1 resp is generated.
- The non-granted cache sees `x_resp` = 0 at all times. Its `x_rdata` is don't-care; drive `pmem_rdata` to both.
- Reset mid-transaction forces `IDLE`, deasserts all strobes and resps, and restores `last_d`. A late `pmem_resp` is then ignored.

## Timing

- Reset/IDLE values:
  - `pmem_read` = `pmem_write` = 0.
  - `i_resp` = `d_resp` = 0.
  - `pmem_address` = 0 and `pmem_wdata` = 0 (latches cleared).
- Grant latency: a request sampled in `IDLE` at edge N drives its `pmem_*` strobe in cycle N+1.
- L1 requesters hold their strobe and address until they see `x_resp`, and deassert in the following cycle.
- The mandatory `IDLE` cycle after each response guarantees that a held-over strobe is never re-granted.
- Back-to-back throughput: one transaction per (pmem latency + 2) cycles.
- With both caches continuously requesting, grants strictly alternate. No requester waits longer than one foreign transaction.
- `pmem_resp` may arrive in the first `SERVE_x` cycle (zero wait) and must be handled.

## Structure

- Add `lc3b_L1_line` (128 bits), `lc3b_word`, and a new `arb_state_t` enum to `lc3b_types`. Also add the constant `L1_OFFSET_BITS = 4` there.
- `l1_mem_arbiter` is a single module with the FSM and the latch registers.
- An optional sub-module, `line_req_reg`, holds the registered address/wdata/type latch with a load enable.
- Later, the arbiter is instantiated inside `cache_hierarchy` in front of L2; the interface is unchanged.

## Test plan

- Reset release, icache reads 0x1234 alone, pmem responds after 3 cycles with line A:
  - `pmem_address` = 0x1230 from cycle 1.
  - `i_resp` and `i_rdata` = A in the response cycle.
  - `d_resp` stays 0.
- Simultaneous icache read 0x0040 and dcache write 0x0080 (wdata B) after reset, `DCACHE_FIRST` = 1:
  - dcache is served first, with `pmem_write` = 1 and `pmem_wdata` = B.
  - icache is served after one `IDLE` cycle.
- Both caches requesting continuously for 6 transactions → grant order D, I, D, I, D, I.
- During `SERVE_I`, icache changes `i_address` and dcache toggles its requests → `pmem_address` and strobes remain unchanged until `pmem_resp`.
- Zero-wait pmem (resp in the first serve cycle) → each transaction completes in 2 cycles, with no duplicate grant when the requester drops its strobe the cycle after resp.
- Assert `rst` in mid-`SERVE_D`, then pulse `pmem_resp` after release → all outputs are 0 and no `d_resp` is generated. `last_d` reset is confirmed by the next contention going to dcache.
